// File: rtl/rx_8b10b_pkg.sv
// Shared types, code constants and lookup functions for the multi-symbol 8b/10b receive decoder.
// Sub-block codes are handled in transmission order: abcdei and fghj, leftmost letter in the MSB.
package rx_8b10b_pkg;

  typedef enum logic [2:0] {
    DISP_NEG,
    DISP_NEU,
    DISP_POS,
    DISP_NEU_RDM,
    DISP_NEU_RDP
  } disp_class_e;

  localparam logic [9:0] K28_5_NEG  = 10'h17C;
  localparam logic [9:0] K28_5_POS  = 10'h283;
  localparam logic [6:0] COMMA_NEG  = K28_5_NEG[6:0];
  localparam logic [6:0] COMMA_POS  = K28_5_POS[6:0];
  localparam logic [5:0] K28_6B_NEG = 6'b001111;
  localparam logic [5:0] K28_6B_POS = 6'b110000;

  typedef struct packed {
    logic       valid;
    logic       k28;
    logic [4:0] edcba;
  } dec6_t;

  typedef struct packed {
    logic       valid;
    logic       alt7;
    logic [2:0] hgf;
  } dec4_t;

  typedef struct packed {
    logic [7:0]  data;
    logic        k;
    logic        dec_err;
    logic        comma;
    disp_class_e cls6;
    disp_class_e cls4;
  } sym_info_t;

  function automatic dec6_t dec6(input logic [5:0] abcdei);
    dec6_t r;
    r = '{valid: 1'b1, k28: 1'b0, edcba: 5'd0};
    case (abcdei)
      6'b100111, 6'b011000: r.edcba = 5'd0;
      6'b011101, 6'b100010: r.edcba = 5'd1;
      6'b101101, 6'b010010: r.edcba = 5'd2;
      6'b110001:            r.edcba = 5'd3;
      6'b110101, 6'b001010: r.edcba = 5'd4;
      6'b101001:            r.edcba = 5'd5;
      6'b011001:            r.edcba = 5'd6;
      6'b111000, 6'b000111: r.edcba = 5'd7;
      6'b111001, 6'b000110: r.edcba = 5'd8;
      6'b100101:            r.edcba = 5'd9;
      6'b010101:            r.edcba = 5'd10;
      6'b110100:            r.edcba = 5'd11;
      6'b001101:            r.edcba = 5'd12;
      6'b101100:            r.edcba = 5'd13;
      6'b011100:            r.edcba = 5'd14;
      6'b010111, 6'b101000: r.edcba = 5'd15;
      6'b011011, 6'b100100: r.edcba = 5'd16;
      6'b100011:            r.edcba = 5'd17;
      6'b010011:            r.edcba = 5'd18;
      6'b110010:            r.edcba = 5'd19;
      6'b001011:            r.edcba = 5'd20;
      6'b101010:            r.edcba = 5'd21;
      6'b011010:            r.edcba = 5'd22;
      6'b111010, 6'b000101: r.edcba = 5'd23;
      6'b110011, 6'b001100: r.edcba = 5'd24;
      6'b100110:            r.edcba = 5'd25;
      6'b010110:            r.edcba = 5'd26;
      6'b110110, 6'b001001: r.edcba = 5'd27;
      6'b001110:            r.edcba = 5'd28;
      K28_6B_NEG, K28_6B_POS: begin
        r.edcba = 5'd28;
        r.k28   = 1'b1;
      end
      6'b101110, 6'b010001: r.edcba = 5'd29;
      6'b011110, 6'b100001: r.edcba = 5'd30;
      6'b101011, 6'b010100: r.edcba = 5'd31;
      default:              r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic dec4_t dec4(input logic [3:0] fghj);
    dec4_t r;
    r = '{valid: 1'b1, alt7: 1'b0, hgf: 3'd0};
    case (fghj)
      4'b1011, 4'b0100: r.hgf = 3'd0;
      4'b1001:          r.hgf = 3'd1;
      4'b0101:          r.hgf = 3'd2;
      4'b1100, 4'b0011: r.hgf = 3'd3;
      4'b1101, 4'b0010: r.hgf = 3'd4;
      4'b1010:          r.hgf = 3'd5;
      4'b0110:          r.hgf = 3'd6;
      4'b1110, 4'b0001: r.hgf = 3'd7;
      4'b0111, 4'b1000: begin
        r.hgf  = 3'd7;
        r.alt7 = 1'b1;
      end
      default:          r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic disp_class_e disp_class6(input logic [5:0] abcdei, input logic valid);
    disp_class_e c;
    c = DISP_NEU;
    if (valid) begin
      if (abcdei == 6'b111000)           c = DISP_NEU_RDM;
      else if (abcdei == 6'b000111)      c = DISP_NEU_RDP;
      else if ($countones(abcdei) == 4)  c = DISP_POS;
      else if ($countones(abcdei) == 2)  c = DISP_NEG;
    end
    return c;
  endfunction

  function automatic disp_class_e disp_class4(input logic [3:0] fghj, input logic valid);
    disp_class_e c;
    c = DISP_NEU;
    if (valid) begin
      if (fghj == 4'b1100)             c = DISP_NEU_RDM;
      else if (fghj == 4'b0011)        c = DISP_NEU_RDP;
      else if ($countones(fghj) == 3)  c = DISP_POS;
      else if ($countones(fghj) == 1)  c = DISP_NEG;
    end
    return c;
  endfunction

  // Returns {violation, rd_after}; rd_after is what the sub-block implies, so a violation resyncs RD.
  function automatic logic [1:0] disp_step(input disp_class_e cls, input logic rd_in);
    logic err;
    logic rd_out;
    err    = 1'b0;
    rd_out = rd_in;
    case (cls)
      DISP_POS:     begin err = rd_in;  rd_out = 1'b1; end
      DISP_NEG:     begin err = !rd_in; rd_out = 1'b0; end
      DISP_NEU_RDM: begin err = rd_in;  rd_out = 1'b0; end
      DISP_NEU_RDP: begin err = !rd_in; rd_out = 1'b1; end
      default:      ;
    endcase
    return {err, rd_out};
  endfunction

endpackage

// File: rtl/rx_8b10b_sym_dec.sv
// Combinational decode of one 10b symbol: byte lookup, K and comma detect, sub-block disparity classes.
module rx_8b10b_sym_dec
  import rx_8b10b_pkg::*;
(
  input  logic [9:0] sym_i,
  output sym_info_t  info_o
);

  logic [5:0] abcdei;
  logic [3:0] fghj;
  dec6_t      d6;
  dec4_t      d4;
  logic       k_alt;
  logic       is_k;

  assign abcdei = {sym_i[0], sym_i[1], sym_i[2], sym_i[3], sym_i[4], sym_i[5]};
  assign fghj   = {sym_i[6], sym_i[7], sym_i[8], sym_i[9]};

  // The RD+ form of K.28 carries the complemented 4b code, so decode it inverted.
  assign d6 = dec6(abcdei);
  assign d4 = dec4((abcdei == K28_6B_POS) ? ~fghj : fghj);

  assign k_alt = d4.alt7 && d6.valid && !d6.k28 &&
                 (d6.edcba inside {5'd23, 5'd27, 5'd29, 5'd30});
  assign is_k  = d6.k28 | k_alt;

  assign info_o.data    = {d4.hgf, d6.edcba};
  assign info_o.k       = is_k;
  assign info_o.dec_err = !d6.valid || !d4.valid || (d4.alt7 && !is_k);
  assign info_o.comma   = (sym_i[6:0] == COMMA_NEG) || (sym_i[6:0] == COMMA_POS);
  assign info_o.cls6    = disp_class6(abcdei, d6.valid);
  assign info_o.cls4    = disp_class4(fghj, d4.valid);

endmodule

// File: rtl/rx_8b10b_decoder_nx.sv
// Two-stage multi-symbol 8b/10b receive decoder: per-symbol lookup, then running-disparity
// chain across the word with error flags and a saturating error counter.
module rx_8b10b_decoder_nx
  import rx_8b10b_pkg::*;
#(
  parameter int NUM_SYM   = 2,
  parameter int ERR_CNT_W = 16
) (
  input  logic                   BitCLK_10,
  input  logic                   Reset,
  input  logic                   RxValid_in,
  input  logic [10*NUM_SYM-1:0]  RxParallel_10,
  input  logic                   ErrCntClr,
  output logic                   RxValid_out,
  output logic [8*NUM_SYM-1:0]   RxParallel_8,
  output logic [NUM_SYM-1:0]     RxDataK,
  output logic [NUM_SYM-1:0]     decode_error,
  output logic [NUM_SYM-1:0]     disparity_error,
  output logic [NUM_SYM-1:0]     comma_det,
  output logic                   RunDisp,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int INC_W = $clog2(NUM_SYM + 1);
  localparam int SUM_W = ERR_CNT_W + INC_W;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  sym_info_t sym_info [NUM_SYM];

  for (genvar gi = 0; gi < NUM_SYM; gi++) begin : g_sym
    rx_8b10b_sym_dec u_sym_dec (
      .sym_i  (RxParallel_10[10*gi +: 10]),
      .info_o (sym_info[gi])
    );
  end

  // Stage 1: registered per-symbol lookup results.
  logic      s1_valid_d, s1_valid_q;
  sym_info_t s1_sym_d [NUM_SYM];
  sym_info_t s1_sym_q [NUM_SYM];

  always_comb begin
    s1_valid_d = RxValid_in;
    s1_sym_d   = s1_sym_q;
    if (RxValid_in) s1_sym_d = sym_info;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++) s1_sym_q[i] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sym_q   <= s1_sym_d;
    end
  end

  // Stage 2: RD chain, error flags and counter.
  logic                 out_valid_d, out_valid_q;
  logic [8*NUM_SYM-1:0] data_d, data_q;
  logic [NUM_SYM-1:0]   k_d, k_q;
  logic [NUM_SYM-1:0]   dec_err_d, dec_err_q;
  logic [NUM_SYM-1:0]   disp_err_d, disp_err_q;
  logic [NUM_SYM-1:0]   comma_d, comma_q;
  logic                 rd_d, rd_q;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic                 rd_chain;
  logic [1:0]           step6, step4;
  logic [INC_W-1:0]     err_inc;
  logic [SUM_W-1:0]     err_sum;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    out_valid_d = s1_valid_q;
    data_d      = data_q;
    k_d         = k_q;
    dec_err_d   = dec_err_q;
    disp_err_d  = disp_err_q;
    comma_d     = comma_q;
    rd_d        = rd_q;
    err_cnt_d   = err_cnt_q;
    rd_chain    = rd_q;
    step6       = '0;
    step4       = '0;
    err_inc     = '0;
    err_sum     = '0;
    if (s1_valid_q) begin
      for (int k = 0; k < NUM_SYM; k++) begin
        data_d[8*k +: 8] = s1_sym_q[k].data;
        k_d[k]           = s1_sym_q[k].k;
        dec_err_d[k]     = s1_sym_q[k].dec_err;
        comma_d[k]       = s1_sym_q[k].comma;
        step6            = disp_step(s1_sym_q[k].cls6, rd_chain);
        step4            = disp_step(s1_sym_q[k].cls4, step6[0]);
        rd_chain         = step4[0];
        disp_err_d[k]    = step6[1] | step4[1];
        err_inc          = err_inc + INC_W'(dec_err_d[k] | disp_err_d[k]);
      end
      rd_d      = rd_chain;
      err_sum   = SUM_W'(err_cnt_q) + SUM_W'(err_inc);
      err_cnt_d = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[ERR_CNT_W-1:0];
    end
    if (ErrCntClr) err_cnt_d = '0;
  end

  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      k_q         <= '0;
      dec_err_q   <= '0;
      disp_err_q  <= '0;
      comma_q     <= '0;
      rd_q        <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      k_q         <= k_d;
      dec_err_q   <= dec_err_d;
      disp_err_q  <= disp_err_d;
      comma_q     <= comma_d;
      rd_q        <= rd_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign RxValid_out     = out_valid_q;
  assign RxParallel_8    = data_q;
  assign RxDataK         = k_q;
  assign decode_error    = dec_err_q;
  assign disparity_error = disp_err_q;
  assign comma_det       = comma_q;
  assign RunDisp         = rd_q;
  assign err_count       = err_cnt_q;

endmodule

// File: tb/tb_rx_8b10b_decoder_nx.sv
// Directed bench for rx_8b10b_decoder_nx (two symbols per word, 4-bit error counter).
module tb_rx_8b10b_decoder_nx;

  localparam int NUM_SYM   = 2;
  localparam int ERR_CNT_W = 4;
  localparam int N_VEC     = 10;

  logic                  BitCLK_10 = 1'b0;
  logic                  Reset = 1'b0;
  logic                  RxValid_in = 1'b0;
  logic [10*NUM_SYM-1:0] RxParallel_10 = '0;
  logic                  ErrCntClr = 1'b0;
  logic                  RxValid_out;
  logic [8*NUM_SYM-1:0]  RxParallel_8;
  logic [NUM_SYM-1:0]    RxDataK;
  logic [NUM_SYM-1:0]    decode_error;
  logic [NUM_SYM-1:0]    disparity_error;
  logic [NUM_SYM-1:0]    comma_det;
  logic                  RunDisp;
  logic [ERR_CNT_W-1:0]  err_count;

  rx_8b10b_decoder_nx #(.NUM_SYM(NUM_SYM), .ERR_CNT_W(ERR_CNT_W)) dut (
    .BitCLK_10       (BitCLK_10),
    .Reset           (Reset),
    .RxValid_in      (RxValid_in),
    .RxParallel_10   (RxParallel_10),
    .ErrCntClr       (ErrCntClr),
    .RxValid_out     (RxValid_out),
    .RxParallel_8    (RxParallel_8),
    .RxDataK         (RxDataK),
    .decode_error    (decode_error),
    .disparity_error (disparity_error),
    .comma_det       (comma_det),
    .RunDisp         (RunDisp),
    .err_count       (err_count)
  );

  always #5 BitCLK_10 = ~BitCLK_10;

  typedef struct {
    logic        vin;
    logic [9:0]  s1;
    logic [9:0]  s0;
    logic        vout;
    logic [15:0] data;
    logic [1:0]  k;
    logic [1:0]  derr;
    logic [1:0]  perr;
    logic [1:0]  comma;
    logic        rd;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [N_VEC];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] s1, input logic [9:0] s0);
    RxValid_in    = v;
    RxParallel_10 = {s1, s0};
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    check({tag, ".valid"}, 32'(RxValid_out), 32'(e.vout));
    check({tag, ".data"},  32'(RxParallel_8), 32'(e.data));
    check({tag, ".k"},     32'(RxDataK), 32'(e.k));
    check({tag, ".derr"},  32'(decode_error), 32'(e.derr));
    check({tag, ".perr"},  32'(disparity_error), 32'(e.perr));
    check({tag, ".comma"}, 32'(comma_det), 32'(e.comma));
    check({tag, ".rd"},    32'(RunDisp), 32'(e.rd));
    check({tag, ".cnt"},   32'(err_count), 32'(e.cnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(RxValid_out), 32'd0);
    check({tag, ".data"},  32'(RxParallel_8), 32'd0);
    check({tag, ".k"},     32'(RxDataK), 32'd0);
    check({tag, ".derr"},  32'(decode_error), 32'd0);
    check({tag, ".perr"},  32'(disparity_error), 32'd0);
    check({tag, ".comma"}, 32'(comma_det), 32'd0);
    check({tag, ".rd"},    32'(RunDisp), 32'd0);
    check({tag, ".cnt"},   32'(err_count), 32'd0);
  endtask

  initial begin
    //        vin   s1       s0        vout  data      k      derr   perr   comma  rd    cnt
    vecs[0] = '{1'b1, 10'h283, 10'h17C, 1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 10'h17C, 10'h17C, 1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b10, 2'b11, 1'b1, 4'd1};
    vecs[2] = '{1'b1, 10'h155, 10'h155, 1'b1, 16'hB5B5, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 4'd1};
    vecs[3] = '{1'b1, 10'h155, 10'h000, 1'b1, 16'hB500, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 4'd2};
    vecs[4] = '{1'b1, 10'h263, 10'h246, 1'b1, 16'h2320, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2};
    vecs[5] = '{1'b1, 10'h17C, 10'h263, 1'b1, 16'hBC23, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 4'd2};
    vecs[6] = '{1'b0, 10'h283, 10'h283, 1'b0, 16'hBC23, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 4'd2};
    vecs[7] = '{1'b0, 10'h283, 10'h283, 1'b0, 16'hBC23, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 4'd2};
    vecs[8] = '{1'b1, 10'h17C, 10'h283, 1'b1, 16'hBCBC, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 4'd2};
    vecs[9] = '{1'b1, 10'h071, 10'h3A8, 1'b1, 16'hF1F7, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 4'd3};

    // Power-on reset.
    drive(1'b0, 10'h0, 10'h0);
    #2 Reset = 1'b1;
    repeat (2) @(negedge BitCLK_10);
    check_zero("reset");
    @(negedge BitCLK_10);
    Reset = 1'b0;

    // Streamed table: output for word i is visible two negedges after it is driven.
    for (int i = 0; i < N_VEC + 2; i++) begin
      @(negedge BitCLK_10);
      if (i >= 2) check_vec($sformatf("vec%0d", i - 2), vecs[i - 2]);
      if (i < N_VEC) drive(vecs[i].vin, vecs[i].s1, vecs[i].s0);
      else           drive(1'b0, 10'h0, 10'h0);
    end

    // Saturation: 20 errored symbols on top of the 3 counted so far.
    exp_cnt = 3;
    for (int j = 0; j < 12; j++) begin
      @(negedge BitCLK_10);
      if (j >= 2) begin
        exp_cnt = (exp_cnt + 2 > 15) ? 15 : exp_cnt + 2;
        check($sformatf("sat%0d.cnt", j - 2), 32'(err_count), 32'(exp_cnt));
        check($sformatf("sat%0d.derr", j - 2), 32'(decode_error), 32'h3);
      end
      if (j < 10) drive(1'b1, 10'h000, 10'h000);
      else        drive(1'b0, 10'h0, 10'h0);
    end
    check("sat.final", 32'(err_count), 32'd15);

    // Clear coinciding with an errored word reaching stage 2.
    @(negedge BitCLK_10);
    drive(1'b1, 10'h000, 10'h000);
    @(negedge BitCLK_10);
    drive(1'b0, 10'h0, 10'h0);
    ErrCntClr = 1'b1;
    @(negedge BitCLK_10);
    ErrCntClr = 1'b0;
    check("clr.valid", 32'(RxValid_out), 32'd1);
    check("clr.derr", 32'(decode_error), 32'h3);
    check("clr.cnt", 32'(err_count), 32'd0);

    // Reset with words in flight while RD is positive.
    @(negedge BitCLK_10);
    drive(1'b1, 10'h263, 10'h17C);
    @(negedge BitCLK_10);
    drive(1'b1, 10'h155, 10'h155);
    @(negedge BitCLK_10);
    check("prerst.valid", 32'(RxValid_out), 32'd1);
    check("prerst.rd", 32'(RunDisp), 32'd1);
    Reset = 1'b1;
    drive(1'b0, 10'h0, 10'h0);
    #1;
    check_zero("midrst");
    @(negedge BitCLK_10);
    Reset = 1'b0;
    drive(1'b1, 10'h263, 10'h17C);
    @(negedge BitCLK_10);
    drive(1'b0, 10'h0, 10'h0);
    check("postrst.flushed", 32'(RxValid_out), 32'd0);
    @(negedge BitCLK_10);
    check("postrst.valid", 32'(RxValid_out), 32'd1);
    check("postrst.data", 32'(RxParallel_8), 32'h23BC);
    check("postrst.k", 32'(RxDataK), 32'h1);
    check("postrst.comma", 32'(comma_det), 32'h1);
    check("postrst.perr", 32'(disparity_error), 32'h0);
    check("postrst.derr", 32'(decode_error), 32'h0);
    check("postrst.rd", 32'(RunDisp), 32'd1);
    check("postrst.cnt", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
